ula_ncl_sequencer: RTL and testbench
====================================

Name: ula_ncl_sequencer

Overview:
- Synchronous front-end that sequences the NCL ALU stage through complete four-phase DATA/NULL wavefront cycles.
- Shares the stage between two clocked requesters using round-robin arbitration.
- Synchronizes the stage's asynchronous acknowledge and completion signals, captures each result and returns it with a requester tag.
- Includes a per-phase watchdog so a stuck stage cannot hang the system.

Parameters:
- WIDTH, 8: operand/result width; must match the ALU stage.
- SYNC_STAGES, 2: flip-flop depth of the synchronizers on async inputs (minimum 2).
- TIMEOUT, 255: maximum clk cycles per wavefront phase before error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  1  requester 0 operation select
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  index of the requester that issued the operation
- resp_result  out  WIDTH  captured ula_soma
- resp_of, resp_neg, resp_zero  out  1 each  decoded flags
- resp_err  out  1  phase timeout occurred on this operation
- busy  out  1  state is not IDLE
- fault  out  1  sticky; NULL phase timed out
- ula_a, ula_b  out  WIDTH  ALU operands; all-zero during NULL
- ula_opr  out  2  dual-rail op: 00 NULL, 01 op=0, 10 op=1; 11 is never driven
- ula_ack_in  out  1  acknowledge to the stage: 1 = request-for-data, 0 = request-for-null
- ula_ack_out  in  1  stage acknowledge (async): 1 = rfd, 0 = rfn
- ula_soma  in  WIDTH  ALU result (async)
- ula_of, ula_neg, ula_zero  in  2 each  dual-rail flags (async): 00 NULL, 01 = 0, 10 = 1

Behaviour:
- Reset values:
  - State is IDLE.
  - All ula_* outputs are 0, except ula_ack_in = 1.
  - All req*_ready and resp_* outputs are 0.
  - busy = 0, fault = 0.
  - The round-robin pointer favours requester 0.
- Completion detection:
  - compl_data = all three flag pairs non-00.
  - compl_null = all three flag pairs 00.
  - Both are computed combinationally, then passed through SYNC_STAGES flip-flops.
  - ula_ack_out passes through its own SYNC_STAGES flip-flops.
  - ula_soma and the flags are sampled only in CAPTURE. NCL monotonicity holds them stable until NULL is requested.
- Registered outputs: all outputs are registered, and ula_a/b/opr change only on state entry.
- State machine:
  - IDLE:
    - If any valid, grant one requester: the one not granted last when both are valid, otherwise the only one valid.
    - Pulse that req_ready for one cycle, latch operands, op and id.
    - Drive ula_a, ula_b and ula_opr = {op, ~op}.
    - Keep ula_ack_in = 1. Clear the timer. Go to DATA.
  - DATA:
    - Wait until synced ack_out = 0 and synced compl_data = 1, then go to CAPTURE.
    - If the timer reaches TIMEOUT: set err_latch and go to NULL.
  - CAPTURE (1 cycle):
    - Register soma, the flags (bit [1] of each pair) and resp_err = 0.
    - Drive ula_ack_in = 0 and return operands to NULL (all 0). Clear the timer. Go to NULL.
  - NULL:
    - ula_ack_in stays 0 until synced compl_null = 1 and synced ack_out = 1.
    - Then set ula_ack_in = 1 and go to RESP.
    - If the timer reaches TIMEOUT: set fault and go to FAULT.
  - RESP:
    - Assert resp_valid and hold all resp_* stable until resp_ready.
    - On the handshake cycle, deassert resp_valid and go to IDLE.
    - A new grant is earliest on the following cycle; no pipelining.
  - Timeout path:
    - On entry to NULL after a DATA timeout: drive NULL and ula_ack_in = 0.
    - Result, of, neg and zero are forced to 0 and resp_err = 1.
  - FAULT:
    - All ula_* are held at NULL values and ula_ack_in = 1.
    - No grants are issued and fault stays 1. Only rst exits.
- Arbitration:
  - The pointer updates only on a grant.
  - Requests arriving while busy wait; there is no queueing.
  - Both requesters valid in the same IDLE cycle: the non-favoured one waits, and the pointer toggles.
- Latency: with SYNC_STAGES = 2 and an ideal stage, the minimum is grant → resp_valid in 7 cycles.
- Reset mid-operation:
  - Everything returns to reset values immediately. ula_opr = 00 forces NULL into the stage.
  - Any in-flight result is discarded without a response.
- Timer: width is clog2(TIMEOUT+1). It saturates, and does not wrap.

Test Plan:
1. Single op, requester 0, a = 0x5A, b = 0xAA, op = 0; the bench ALU model adds with a 3-cycle delay → ula_opr = 01 during DATA. Response: resp_result = 0x04, of = 0, neg = 0, zero = 0, resp_id = 0, resp_err = 0. ula_ack_in goes 1 → 0 → 1.
2. Requester 1, a = 0x5A, b = 0xAA, op = 1 (subtract) → ula_opr = 10. Response: resp_result = 0xB0, of = 1, neg = 1, zero = 0, resp_id = 1.
3. Both valid in the same cycle for 4 operations → resp_id sequence is 0, 1, 0, 1. Exactly one ready pulse per grant.
4. Model never completes DATA (flags stuck at 00), TIMEOUT = 16 → response after ~16 cycles in DATA with resp_err = 1 and result 0x00. Next operation then succeeds.
5. Model holds flags non-NULL forever after ula_ack_in = 0 → fault = 1 and no further grants. rst clears fault; the next operation completes normally.
6. Backpressure: resp_ready = 0 for 10 cycles with req0_valid held → resp_* stable and no new grant. Also assert rst during DATA → outputs reach reset values asynchronously, with ula_opr = 00 and no response.

Source files
------------

// File: rtl/ula_ncl_sequencer.sv
// ula_ncl_sequencer
// -----------------
// Clocked front-end for a self-timed (NCL) ALU stage. It arbitrates between two
// clocked requesters, drives one complete DATA/NULL wavefront cycle through the
// stage per operation, and returns the captured result tagged with the
// requester index. A per-phase watchdog keeps a stuck stage from hanging the
// system.
//
// Handshake semantics (all clocked interfaces):
//   req*_ready is a one-cycle registered pulse. It means "your operands were
//   latched on the previous edge". The requester may drop or change
//   req*_valid/operands from that cycle on.
//   resp_valid stays high, with every resp_* field stable, until resp_ready is
//   seen high on a rising edge. That edge completes the transfer.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req{0,1}_valid/ready      requester handshakes
//   req{0,1}_a/_b/_op         requester operands and operation select
//   resp_valid/ready          response handshake
//   resp_id                   index of the requester that issued the operation
//   resp_result/of/neg/zero   captured result and decoded flags
//   resp_err                  this operation's DATA phase timed out
//   busy                      state is not IDLE
//   fault                     sticky; NULL phase timed out (only rst clears it)
//   ula_a/_b/_opr             dual-rail-encoded operands to the stage (0 = NULL)
//   ula_ack_in                1 = request-for-data, 0 = request-for-null
//   ula_ack_out, ula_soma,
//   ula_of/_neg/_zero         asynchronous returns from the stage
//   state_dbg                 current FSM state, for observation only
module ula_ncl_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_of,
    output logic             resp_neg,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             busy,
    output logic             fault,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [1:0]       ula_opr,
    output logic             ula_ack_in,
    input  logic             ula_ack_out,
    input  logic [WIDTH-1:0] ula_soma,
    input  logic [1:0]       ula_of,
    input  logic [1:0]       ula_neg,
    input  logic [1:0]       ula_zero,
    output logic [2:0]       state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DATA    = 3'd1,
        S_CAPTURE = 3'd2,
        S_NULL    = 3'd3,
        S_RESP    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t state, state_d;

    logic [TW-1:0] timer, timer_d, timer_inc;
    logic          last_id, last_id_d;   // requester granted most recently
    logic          cur_id, cur_id_d;     // requester owning the in-flight operation

    logic             req0_ready_d, req1_ready_d;
    logic             resp_valid_d, resp_id_d;
    logic [WIDTH-1:0] resp_result_d;
    logic             resp_of_d, resp_neg_d, resp_zero_d, resp_err_d;
    logic             fault_d;
    logic [WIDTH-1:0] ula_a_d, ula_b_d;
    logic [1:0]       ula_opr_d;
    logic             ula_ack_in_d;

    // Completion detection on the raw dual-rail flags, then synchronized.
    logic compl_data, compl_null;
    assign compl_data = (ula_of != 2'b00) && (ula_neg != 2'b00) && (ula_zero != 2'b00);
    assign compl_null = (ula_of == 2'b00) && (ula_neg == 2'b00) && (ula_zero == 2'b00);

    logic [SYNC_STAGES-1:0] ack_sync, cd_sync, cn_sync;
    logic                   ack_s, cd_s, cn_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_sync <= '0;
            cd_sync  <= '0;
            cn_sync  <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ula_ack_out};
            cd_sync  <= {cd_sync[SYNC_STAGES-2:0], compl_data};
            cn_sync  <= {cn_sync[SYNC_STAGES-2:0], compl_null};
        end
    end

    assign ack_s = ack_sync[SYNC_STAGES-1];
    assign cd_s  = cd_sync[SYNC_STAGES-1];
    assign cn_s  = cn_sync[SYNC_STAGES-1];

    // Grant selection: with both valid, the one not granted last wins.
    logic             grant1;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_op;
    assign grant1 = req1_valid && (!req0_valid || !last_id);
    assign sel_a  = grant1 ? req1_a  : req0_a;
    assign sel_b  = grant1 ? req1_b  : req0_b;
    assign sel_op = grant1 ? req1_op : req0_op;

    assign timer_inc = (timer == TMAX) ? timer : timer + 1'b1;

    always_comb begin
        state_d       = state;
        timer_d       = timer;
        last_id_d     = last_id;
        cur_id_d      = cur_id;
        req0_ready_d  = 1'b0;
        req1_ready_d  = 1'b0;
        resp_valid_d  = resp_valid;
        resp_id_d     = resp_id;
        resp_result_d = resp_result;
        resp_of_d     = resp_of;
        resp_neg_d    = resp_neg;
        resp_zero_d   = resp_zero;
        resp_err_d    = resp_err;
        fault_d       = fault;
        ula_a_d       = ula_a;
        ula_b_d       = ula_b;
        ula_opr_d     = ula_opr;
        ula_ack_in_d  = ula_ack_in;

        case (state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready_d = !grant1;
                    req1_ready_d = grant1;
                    last_id_d    = grant1;
                    cur_id_d     = grant1;
                    ula_a_d      = sel_a;
                    ula_b_d      = sel_b;
                    ula_opr_d    = {sel_op, ~sel_op};
                    ula_ack_in_d = 1'b1;
                    timer_d      = '0;
                    state_d      = S_DATA;
                end
            end

            S_DATA: begin
                timer_d = timer_inc;
                if (!ack_s && cd_s) begin
                    state_d = S_CAPTURE;
                end else if (timer == TMAX) begin
                    // Abandon the wavefront: push NULL and report an error result.
                    resp_id_d     = cur_id;
                    resp_result_d = '0;
                    resp_of_d     = 1'b0;
                    resp_neg_d    = 1'b0;
                    resp_zero_d   = 1'b0;
                    resp_err_d    = 1'b1;
                    ula_a_d       = '0;
                    ula_b_d       = '0;
                    ula_opr_d     = 2'b00;
                    ula_ack_in_d  = 1'b0;
                    timer_d       = '0;
                    state_d       = S_NULL;
                end
            end

            S_CAPTURE: begin
                // Stage outputs are held stable by monotonicity until NULL is requested.
                resp_id_d     = cur_id;
                resp_result_d = ula_soma;
                resp_of_d     = ula_of[1];
                resp_neg_d    = ula_neg[1];
                resp_zero_d   = ula_zero[1];
                resp_err_d    = 1'b0;
                ula_a_d       = '0;
                ula_b_d       = '0;
                ula_opr_d     = 2'b00;
                ula_ack_in_d  = 1'b0;
                timer_d       = '0;
                state_d       = S_NULL;
            end

            S_NULL: begin
                timer_d = timer_inc;
                if (cn_s && ack_s) begin
                    ula_ack_in_d = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else if (timer == TMAX) begin
                    fault_d      = 1'b1;
                    ula_ack_in_d = 1'b1;
                    state_d      = S_FAULT;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end

            S_FAULT: begin
                // Terminal until reset; outputs already hold NULL with ack_in = 1.
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            last_id     <= 1'b1;     // so requester 0 is favoured first
            cur_id      <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_of     <= 1'b0;
            resp_neg    <= 1'b0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b0;
            ula_a       <= '0;
            ula_b       <= '0;
            ula_opr     <= 2'b00;
            ula_ack_in  <= 1'b1;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            last_id     <= last_id_d;
            cur_id      <= cur_id_d;
            req0_ready  <= req0_ready_d;
            req1_ready  <= req1_ready_d;
            resp_valid  <= resp_valid_d;
            resp_id     <= resp_id_d;
            resp_result <= resp_result_d;
            resp_of     <= resp_of_d;
            resp_neg    <= resp_neg_d;
            resp_zero   <= resp_zero_d;
            resp_err    <= resp_err_d;
            busy        <= (state_d != S_IDLE);
            fault       <= fault_d;
            ula_a       <= ula_a_d;
            ula_b       <= ula_b_d;
            ula_opr     <= ula_opr_d;
            ula_ack_in  <= ula_ack_in_d;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_ula_ncl_sequencer.sv
// Testbench for ula_ncl_sequencer with a behavioural NCL ALU stage model
// (add/subtract, 3-cycle response delay, optional stuck DATA or stuck NULL).
module tb_ula_ncl_sequencer;

    localparam int W   = 8;
    localparam int DLY = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_op = 1'b0, req1_op = 1'b0;
    logic         resp_valid, resp_id, resp_of, resp_neg, resp_zero, resp_err;
    logic         resp_ready = 1'b1;
    logic [W-1:0] resp_result;
    logic         busy, fault;
    logic [W-1:0] ula_a, ula_b;
    logic [1:0]   ula_opr;
    logic         ula_ack_in;
    logic         ula_ack_out = 1'b1;
    logic [W-1:0] ula_soma = '0;
    logic [1:0]   ula_of = 2'b00, ula_neg = 2'b00, ula_zero = 2'b00;
    logic [2:0]   state_dbg;

    int total = 0;
    int bad   = 0;
    // Expected response: {id, err, of, neg, zero, result}
    logic [12:0] exp_q[$];

    ula_ncl_sequencer #(.WIDTH(W), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_of(resp_of), .resp_neg(resp_neg),
        .resp_zero(resp_zero), .resp_err(resp_err),
        .busy(busy), .fault(fault),
        .ula_a(ula_a), .ula_b(ula_b), .ula_opr(ula_opr), .ula_ack_in(ula_ack_in),
        .ula_ack_out(ula_ack_out), .ula_soma(ula_soma),
        .ula_of(ula_of), .ula_neg(ula_neg), .ula_zero(ula_zero),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- stage model ----------------
    // mode: 0 normal, 1 never completes DATA, 2 never returns to NULL
    int mode  = 0;
    int m_cnt = 0;

    function automatic logic [10:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic op);
        logic [W-1:0] r;
        logic         v;
        r = op ? (a - b) : (a + b);
        v = op ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1]))
               : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
        return {v, r[W-1], (r == '0), r};
    endfunction

    always @(posedge clk) begin
        logic [10:0] res;
        if (ula_ack_out) begin
            if (ula_ack_in && ula_opr != 2'b00 && mode != 1) begin
                if (m_cnt == DLY - 1) begin
                    res = alu(ula_a, ula_b, ula_opr[1]);
                    ula_soma    <= res[7:0];
                    ula_zero    <= res[8]  ? 2'b10 : 2'b01;
                    ula_neg     <= res[9]  ? 2'b10 : 2'b01;
                    ula_of      <= res[10] ? 2'b10 : 2'b01;
                    ula_ack_out <= 1'b0;
                    m_cnt       <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end else begin
            if ((!ula_ack_in || ula_opr == 2'b00) && mode != 2) begin
                if (m_cnt == DLY - 1) begin
                    ula_soma    <= '0;
                    ula_of      <= 2'b00;
                    ula_neg     <= 2'b00;
                    ula_zero    <= 2'b00;
                    ula_ack_out <= 1'b1;
                    m_cnt       <= 0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else begin
                m_cnt <= 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic op, input int limit, output logic to);
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end
        to = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready === 1'b1) || (id == 1'b1 && req1_ready === 1'b1)) begin
                to = 1'b0;
                break;
            end
        end
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output logic to, output logic [12:0] got,
                             output logic saw_low, output int cycles);
        to = 1'b1; saw_low = 1'b0; got = '0; cycles = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            cycles++;
            if (ula_ack_in === 1'b0) saw_low = 1'b1;
            if (resp_valid === 1'b1) begin
                got = {resp_id, resp_err, resp_of, resp_neg, resp_zero, resp_result};
                to  = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({ula_a, ula_b, ula_opr, ula_ack_in} !== {8'h00, 8'h00, 2'b00, 1'b1}) begin
            bad++; $display("FAIL reset_ula got=%h/%h/%b/%b exp=00/00/00/1", ula_a, ula_b, ula_opr, ula_ack_in);
        end
        total++;
        if ({req0_ready, req1_ready, resp_valid, resp_err, resp_result, busy, fault} !== 13'h0) begin
            bad++; $display("FAIL reset_ctrl got r0=%b r1=%b rv=%b re=%b rr=%h busy=%b fault=%b exp all 0",
                            req0_ready, req1_ready, resp_valid, resp_err, resp_result, busy, fault);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if ({busy, ula_ack_in, ula_opr, state_dbg} !== {1'b0, 1'b1, 2'b00, 3'd0}) begin
            bad++; $display("FAIL reset_idle got busy=%b ack_in=%b opr=%b st=%0d exp 0/1/00/0",
                            busy, ula_ack_in, ula_opr, state_dbg);
        end
    endtask

    task automatic test_single_req0();
        logic to, saw_low; logic [12:0] got, exp; int cyc;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h04});
        issue(1'b0, 8'h5A, 8'hAA, 1'b0, 20, to);
        total++;
        if (to) begin bad++; $display("FAIL single0_grant got=timeout exp=ready pulse"); end
        total++;
        if ({ula_opr, ula_ack_in, ula_a, ula_b} !== {2'b01, 1'b1, 8'h5A, 8'hAA}) begin
            bad++; $display("FAIL single0_drive got opr=%b ack=%b a=%h b=%h exp 01/1/5a/aa", ula_opr, ula_ack_in, ula_a, ula_b);
        end
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL single0_resp got=%h to=%b exp=%h", got, to, exp); end
        total++;
        if (!saw_low || ula_ack_in !== 1'b1) begin
            bad++; $display("FAIL single0_ack got saw_low=%b ack_in=%b exp 1/1", saw_low, ula_ack_in);
        end
        @(negedge clk);
    endtask

    task automatic test_single_req1();
        logic to, saw_low; logic [12:0] got, exp; int cyc;
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB0});
        issue(1'b1, 8'h5A, 8'hAA, 1'b1, 20, to);
        total++;
        if (to || ula_opr !== 2'b10) begin bad++; $display("FAIL single1_opr got opr=%b to=%b exp=10", ula_opr, to); end
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL single1_resp got=%h to=%b exp=%h", got, to, exp); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [W-1:0] a0[2], b0[2], a1[2], b1[2];
        logic o0[2], o1[2];
        logic [12:0] got, exp;
        int i0, i1, nresp, p0, p1;
        a0[0] = 8'h01; b0[0] = 8'hFF; o0[0] = 1'b0;
        a0[1] = 8'h10; b0[1] = 8'h20; o0[1] = 1'b1;
        a1[0] = 8'h7F; b1[0] = 8'h01; o1[0] = 1'b0;
        a1[1] = 8'h80; b1[1] = 8'h01; o1[1] = 1'b1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80});
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hF0});
        exp_q.push_back({1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h7F});
        i0 = 0; i1 = 0; nresp = 0; p0 = 0; p1 = 0;
        req0_a = a0[0]; req0_b = b0[0]; req0_op = o0[0]; req0_valid = 1'b1;
        req1_a = a1[0]; req1_b = b1[0]; req1_op = o1[0]; req1_valid = 1'b1;
        for (int c = 0; c < 400 && nresp < 4; c++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) begin
                p0++; i0++;
                if (i0 < 2) begin req0_a = a0[i0]; req0_b = b0[i0]; req0_op = o0[i0]; end
                else req0_valid = 1'b0;
            end
            if (req1_ready === 1'b1) begin
                p1++; i1++;
                if (i1 < 2) begin req1_a = a1[i1]; req1_b = b1[i1]; req1_op = o1[i1]; end
                else req1_valid = 1'b0;
            end
            if (resp_valid === 1'b1) begin
                got = {resp_id, resp_err, resp_of, resp_neg, resp_zero, resp_result};
                exp = exp_q.pop_front();
                total++;
                if (got !== exp) begin bad++; $display("FAIL rr_resp%0d got=%h exp=%h", nresp, got, exp); end
                nresp++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        total++;
        if (nresp != 4) begin bad++; $display("FAIL rr_count got=%0d exp=4", nresp); exp_q.delete(); end
        total++;
        if (p0 != 2 || p1 != 2) begin bad++; $display("FAIL rr_pulses got p0=%0d p1=%0d exp 2/2", p0, p1); end
        @(negedge clk);
    endtask

    task automatic test_data_timeout();
        logic to, saw_low; logic [12:0] got, exp; int cyc;
        mode = 1;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        issue(1'b0, 8'h12, 8'h34, 1'b0, 20, to);
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL tmo_resp got=%h to=%b exp=%h", got, to, exp); end
        total++;
        if (cyc < 17 || cyc > 19) begin bad++; $display("FAIL tmo_latency got=%0d exp=17..19", cyc); end
        total++;
        if (fault !== 1'b0) begin bad++; $display("FAIL tmo_fault got=%b exp=0", fault); end
        mode = 0;
        @(negedge clk);
        exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h07});
        issue(1'b1, 8'h03, 8'h04, 1'b0, 20, to);
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL tmo_next got=%h to=%b exp=%h", got, to, exp); end
        @(negedge clk);
    endtask

    task automatic test_null_fault();
        logic to, saw_low, seen_resp; logic [12:0] got, exp; int cyc, grants;
        mode = 2;
        issue(1'b0, 8'h22, 8'h11, 1'b1, 20, to);
        to = 1'b1; seen_resp = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen_resp = 1'b1;
            if (fault === 1'b1) begin to = 1'b0; break; end
        end
        total++;
        if (to) begin bad++; $display("FAIL fault_set got fault=%b exp=1", fault); end
        total++;
        if ({busy, ula_ack_in, ula_opr, seen_resp} !== {1'b1, 1'b1, 2'b00, 1'b0}) begin
            bad++; $display("FAIL fault_outputs got busy=%b ack=%b opr=%b resp=%b exp 1/1/00/0",
                            busy, ula_ack_in, ula_opr, seen_resp);
        end
        req1_a = 8'h01; req1_b = 8'h02; req1_op = 1'b0; req1_valid = 1'b1;
        grants = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req1_ready === 1'b1 || req0_ready === 1'b1 || resp_valid === 1'b1) grants++;
        end
        req1_valid = 1'b0;
        total++;
        if (grants != 0 || fault !== 1'b1) begin bad++; $display("FAIL fault_nogrant got=%0d fault=%b exp 0/1", grants, fault); end
        mode = 0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({fault, busy, ula_ack_in} !== 3'b001) begin
            bad++; $display("FAIL fault_clear got fault=%b busy=%b ack=%b exp 0/0/1", fault, busy, ula_ack_in);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02});
        issue(1'b0, 8'h05, 8'h03, 1'b1, 20, to);
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL fault_after got=%h to=%b exp=%h", got, to, exp); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic to, saw_low, grant_seen; logic [12:0] got, exp, now; int cyc;
        resp_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h80});
        issue(1'b0, 8'h40, 8'h40, 1'b0, 20, to);
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL bp_resp got=%h to=%b exp=%h", got, to, exp); end
        req0_a = 8'h01; req0_b = 8'h01; req0_op = 1'b0; req0_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            now = {resp_id, resp_err, resp_of, resp_neg, resp_zero, resp_result};
            total++;
            if (resp_valid !== 1'b1 || now !== exp || req0_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold%0d got rv=%b resp=%h rdy=%b exp 1/%h/0", c, resp_valid, now, req0_ready, exp);
            end
        end
        resp_ready = 1'b1;
        grant_seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req0_ready === 1'b1) begin grant_seen = 1'b1; break; end
        end
        req0_valid = 1'b0;
        total++;
        if (!grant_seen) begin bad++; $display("FAIL bp_regrant got=none exp=ready pulse"); end
        exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02});
        wait_resp(100, to, got, saw_low, cyc);
        exp = exp_q.pop_front();
        total++;
        if (to || got !== exp) begin bad++; $display("FAIL bp_second got=%h to=%b exp=%h", got, to, exp); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic to; int seen;
        issue(1'b1, 8'h0F, 8'h01, 1'b0, 20, to);
        @(negedge clk);
        total++;
        if (to || state_dbg !== 3'd1) begin bad++; $display("FAIL rmid_state got st=%0d to=%b exp=1", state_dbg, to); end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({ula_a, ula_b, ula_opr, ula_ack_in, busy, resp_valid} !== {8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0}) begin
            bad++; $display("FAIL rmid_async got a=%h b=%h opr=%b ack=%b busy=%b rv=%b exp 00/00/00/1/0/0",
                            ula_a, ula_b, ula_opr, ula_ack_in, busy, resp_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_noresp got=%0d busy=%b exp 0/0", seen, busy); end
    endtask

    initial begin
        test_reset();
        test_single_req0();
        test_single_req1();
        test_round_robin();
        test_data_timeout();
        test_null_fault();
        test_backpressure();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got=time limit exp=completion");
        $fatal(1, "time limit");
    end

endmodule
